// File: rtl/lat_tester_ctrl_if.sv
// Signal bundle between the latency-tester sequencer and its host/pattern side.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface lat_tester_ctrl_if;
  logic        start;
  logic        abort;
  logic [1:0]  lt_sel;
  logic        VSYNC_in;
  logic        sensor_in;
  logic        lt_active;
  logic [1:0]  lt_mode;
  logic        busy;
  logic        finished;
  logic        timeout;
  logic [15:0] latency;
  logic [15:0] stb_time;

  modport master (
    output start, abort, lt_sel, VSYNC_in, sensor_in,
    input  lt_active, lt_mode, busy, finished, timeout, latency, stb_time
  );

  modport slave (
    input  start, abort, lt_sel, VSYNC_in, sensor_in,
    output lt_active, lt_mode, busy, finished, timeout, latency, stb_time
  );
endinterface

// File: rtl/lat_tester_ctrl.sv
// Video latency tester sequencer. Shows PREP_FRAMES black frames, flashes a
// box through lt_mode, then times sensor-bright (latency) and, after the box
// is removed, sensor-dark (stb_time), both in microseconds.
// Optional feature: define LT_DEBOUNCE_EN to debounce the synchronised sensor.
module lat_tester_ctrl #(
`ifdef LT_DEBOUNCE_EN
  parameter logic [7:0]  DEBOUNCE_CYC = 8'd135,
`endif
  parameter int unsigned PREP_FRAMES  = 4,
  parameter int unsigned US_DIV       = 27,
  parameter logic [15:0] TIMEOUT_US   = 16'd60000
) (
  input  logic             clk27,
  input  logic             reset_n,
  lat_tester_ctrl_if.slave bus
);

  localparam logic [4:0] PSC_LAST  = 5'(US_DIV - 1);
  localparam logic [7:0] PREP_LAST = 8'(PREP_FRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_MEAS_LAT, S_HOLD, S_MEAS_STB, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  prep_cnt_q, prep_cnt_d;
  logic [4:0]  psc_q, psc_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [1:0]  lt_mode_q, lt_mode_d;
  logic        finished_q, finished_d;
  logic        timeout_q, timeout_d;
  logic [15:0] latency_q, latency_d;
  logic [15:0] stb_q, stb_d;
  logic        sens_meta_q, sens_sync_q;
  logic        vs_q, vs_fall_q;
  logic        sens_seen;
  logic        cnt_clr;

  // Two-flop sensor synchroniser and registered VSYNC falling-edge detect.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      sens_meta_q <= 1'b0;
      sens_sync_q <= 1'b0;
      vs_q        <= 1'b0;
      vs_fall_q   <= 1'b0;
    end else begin
      sens_meta_q <= bus.sensor_in;
      sens_sync_q <= sens_meta_q;
      vs_q        <= bus.VSYNC_in;
      vs_fall_q   <= vs_q & ~bus.VSYNC_in;
    end
  end

`ifdef LT_DEBOUNCE_EN
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       sens_deb_q, sens_deb_d;

  // Adopt a new sensor level only after it has held for DEBOUNCE_CYC cycles.
  always_comb begin
    deb_cnt_d  = 8'd0;
    sens_deb_d = sens_deb_q;
    if (sens_sync_q != sens_deb_q) begin
      if (deb_cnt_q == DEBOUNCE_CYC - 8'd1) begin
        sens_deb_d = sens_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt_q  <= 8'd0;
      sens_deb_q <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      sens_deb_q <= sens_deb_d;
    end
  end

  assign sens_seen = sens_deb_q;
`else
  assign sens_seen = sens_sync_q;
`endif

  // Sequencer next-state and result capture; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    prep_cnt_d = prep_cnt_q;
    lt_mode_d  = lt_mode_q;
    finished_d = 1'b0;
    timeout_d  = timeout_q;
    latency_d  = latency_q;
    stb_d      = stb_q;
    cnt_clr    = 1'b0;
    if (bus.abort) begin
      state_d   = S_IDLE;
      lt_mode_d = 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          lt_mode_d = 2'b00;
          if (bus.start) begin
            state_d    = S_PREP;
            timeout_d  = 1'b0;
            sel_d      = bus.lt_sel;
            prep_cnt_d = 8'd0;
          end
        end
        S_PREP: begin
          if (vs_fall_q) begin
            if (prep_cnt_q == PREP_LAST) begin
              if (sens_seen) begin
                // Sensor already bright before any box: measurement is invalid.
                state_d   = S_DONE;
                timeout_d = 1'b1;
                latency_d = 16'hFFFF;
              end else begin
                state_d   = S_MEAS_LAT;
                lt_mode_d = sel_q;
                cnt_clr   = 1'b1;
              end
            end else begin
              prep_cnt_d = prep_cnt_q + 8'd1;
            end
          end
        end
        S_MEAS_LAT: begin
          if (sens_seen) begin
            latency_d = us_cnt_q;
            state_d   = S_HOLD;
          end else if (us_cnt_q == TIMEOUT_US) begin
            timeout_d = 1'b1;
            latency_d = 16'hFFFF;
            lt_mode_d = 2'b00;
            state_d   = S_DONE;
          end
        end
        S_HOLD: begin
          if (vs_fall_q) begin
            state_d   = S_MEAS_STB;
            lt_mode_d = 2'b00;
            cnt_clr   = 1'b1;
          end
        end
        S_MEAS_STB: begin
          if (!sens_seen) begin
            stb_d   = us_cnt_q;
            state_d = S_DONE;
          end else if (us_cnt_q == TIMEOUT_US) begin
            timeout_d = 1'b1;
            stb_d     = 16'hFFFF;
            state_d   = S_DONE;
          end
        end
        S_DONE: begin
          state_d    = S_IDLE;
          finished_d = 1'b1;
        end
        default: begin
          state_d   = S_IDLE;
          lt_mode_d = 2'b00;
        end
      endcase
    end
  end

  // Microsecond prescaler and saturating us counter, restarted on measure entry.
  always_comb begin
    psc_d    = psc_q;
    us_cnt_d = us_cnt_q;
    if (cnt_clr) begin
      psc_d    = 5'd0;
      us_cnt_d = 16'd0;
    end else if (state_q == S_MEAS_LAT || state_q == S_MEAS_STB) begin
      if (psc_q == PSC_LAST) begin
        psc_d = 5'd0;
        if (us_cnt_q != 16'hFFFF) begin
          us_cnt_d = us_cnt_q + 16'd1;
        end
      end else begin
        psc_d = psc_q + 5'd1;
      end
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'b00;
      prep_cnt_q <= 8'd0;
      psc_q      <= 5'd0;
      us_cnt_q   <= 16'd0;
      lt_mode_q  <= 2'b00;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      latency_q  <= 16'd0;
      stb_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      prep_cnt_q <= prep_cnt_d;
      psc_q      <= psc_d;
      us_cnt_q   <= us_cnt_d;
      lt_mode_q  <= lt_mode_d;
      finished_q <= finished_d;
      timeout_q  <= timeout_d;
      latency_q  <= latency_d;
      stb_q      <= stb_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.lt_active = (state_q != S_IDLE);
  assign bus.lt_mode   = lt_mode_q;
  assign bus.finished  = finished_q;
  assign bus.timeout   = timeout_q;
  assign bus.latency   = latency_q;
  assign bus.stb_time  = stb_q;

endmodule
